gen_pipe_crd_sink: RTL and testbench
====================================

# gen_pipe_crd_sink

Credit-controlled output buffer that sits directly downstream of a fixed-latency, non-stallable pipe (gen_pipe family). Holds up to FIFO_D pipe results and presents them to a consumer over a valid/ready handshake. A credit counter gates issue at the pipe head, so the pipe never delivers data into a full buffer. Protocol violations are flagged with sticky error bits.

## Interface
- FIFO_D, 4, buffer depth in entries and initial credit count; ≥ 2, power of 2.
- DAT_W, 4, data width.
- CNT_W, $clog2(FIFO_D+1), width of the credit and occupancy counters; derived, not overridden.

- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- iss_in  in  1  upstream issues one item into the pipe head this cycle.
- rdy_iss  out  1  credit available; upstream may assert iss_in only when this is high.
- dat_in  in  DAT_W  data from pipe tail.
- vld_in  in  1  valid from pipe tail.
- dat_out  out  DAT_W  head-of-buffer data; 0 when empty.
- vld_out  out  1  buffer non-empty.
- rdy_out  in  1  consumer ready; pop = vld_out & rdy_out.
- crd_cnt  out  CNT_W  current credits.
- occ  out  CNT_W  current occupancy.
- err_iss  out  1  sticky; iss_in seen with zero credits.
- err_ovf  out  1  sticky; vld_in seen while full with no pop.

## Operation
- **Storage:** FIFO_D-entry register array, log2(FIFO_D)-bit write and read pointers. Pointers wrap naturally at FIFO_D.
- **Show-ahead output:** dat_out = mem[rd_ptr] when occ≠0, else 0. vld_out = (occ≠0). Both are decoded from registers, with no combinational path from inputs.
- **Pop:** pop = vld_out & rdy_out. It advances rd_ptr.
- **Write:** wr = vld_in & (occ<FIFO_D | pop). It writes mem[wr_ptr] and advances wr_ptr. A write into a full buffer with a simultaneous pop is legal.
- **Overflow:** vld_in & occ==FIFO_D & ~pop drops the data. Pointers and occ are unchanged, and err_ovf is set.
- **Occupancy:** occ_next = occ + wr − pop.
- **Credits:** iss_ok = iss_in & (crd_cnt≠0). crd_next = crd_cnt − iss_ok + pop.
  - Simultaneous iss_ok and pop leaves the count unchanged.
  - With crd_cnt==0, iss_in and pop in the same cycle: iss_in is not counted and err_iss is set. The pop still returns its credit, so crd_next = 1.
- **rdy_iss:** rdy_iss = (crd_cnt≠0), decoded from the register.
- **Invariant:** crd_cnt + occ + items in flight in the pipe = FIFO_D whenever no error bit is set. crd_cnt never exceeds FIFO_D; a pop is only possible after a prior credited issue.
- **Errors:** err_iss and err_ovf clear only on reset.
- **Data visibility:** no bypass. Data written in cycle N is first visible on dat_out in cycle N+1.

## Timing
- **Reset** (rst_n low at a clk edge) loads:
  - wr_ptr = rd_ptr = 0, occ = 0, crd_cnt = FIFO_D;
  - err_iss = err_ovf = 0;
  - vld_out = 0, dat_out = 0, rdy_iss = 1.
- **Reset during operation:** reset mid-operation discards all buffered data and in-flight accounting. Upstream must flush or reset the pipe in the same cycle. The memory array is not reset.
- **Latency:** vld_in in cycle N gives vld_out in cycle N+1 (buffer empty case). Issue-to-output latency through a DEPTH-stage pipe is DEPTH+1.
- **Credit return:** a pop in cycle N raises crd_cnt, and rdy_iss if it was low, in cycle N+1.
- **Throughput:** back-to-back 1 item/cycle with rdy_out held high requires FIFO_D ≥ DEPTH+2.

## Test plan
- **Reset values:** hold rst_n low 2 cycles, FIFO_D=4 → crd_cnt=4, occ=0, vld_out=0, dat_out=0, rdy_iss=1, both errors 0.
- **Single item, pipe DEPTH=2:** iss_in in cycle 0, vld_in/dat_in=0xA in cycle 2, rdy_out=1 → crd_cnt=3 in cycle 1; vld_out=1, dat_out=0xA in cycle 3; crd_cnt=4 in cycle 4.
- **Fill and stall:** rdy_out=0, 4 issues and 4 deliveries (0x1..0x4) → rdy_iss=0 after the 4th issue, occ=4. A 5th iss_in sets err_iss and crd_cnt stays 0. Then rdy_out=1 pops 0x1,0x2,0x3,0x4 in order.
- **Full write + pop:** occ=4, vld_in=1 with rdy_out=1 in the same cycle → no err_ovf, occ stays 4, new data appears at position 4. Repeat with rdy_out=0 → data dropped, err_ovf=1, occ=4.
- **Wrap-around:** stream 0x0..0x9 continuously with rdy_out toggling 1,0 → output sequence 0x0..0x9 intact, pointers wrap twice, no error bits set.
- **Reset mid-operation:** occ=3, crd_cnt=1, assert rst_n low for 1 cycle → next cycle occ=0, crd_cnt=4, vld_out=0, errors cleared.

Source files
------------

// File: rtl/gen_pipe_crd_sink.sv
// Credit-gated output buffer for a fixed-latency, non-stallable pipe.
// Credits are consumed at pipe issue and returned on consumer pop, so the pipe never overruns the buffer.
module gen_pipe_crd_sink #(
    parameter  int FIFO_D = 4,
    parameter  int DAT_W  = 4,
    localparam int CNT_W  = $clog2(FIFO_D + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iss_in,
    output logic             rdy_iss,
    input  logic [DAT_W-1:0] dat_in,
    input  logic             vld_in,
    output logic [DAT_W-1:0] dat_out,
    output logic             vld_out,
    input  logic             rdy_out,
    output logic [CNT_W-1:0] crd_cnt,
    output logic [CNT_W-1:0] occ,
    output logic             err_iss,
    output logic             err_ovf
);

    localparam int              ADDR_W = $clog2(FIFO_D);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(FIFO_D);

    logic [DAT_W-1:0]  mem [FIFO_D];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr_next;
    logic [ADDR_W-1:0] rd_ptr_next;
    logic [CNT_W-1:0]  occ_next;
    logic [CNT_W-1:0]  crd_next;
    logic              err_iss_next;
    logic              err_ovf_next;

    logic full;
    logic pop;
    logic wr;
    logic ovf;
    logic iss_ok;
    logic iss_bad;

    assign full    = (occ == FULL);
    assign vld_out = (occ != '0);
    assign dat_out = vld_out ? mem[rd_ptr] : '0;
    assign rdy_iss = (crd_cnt != '0);

    assign pop     = vld_out & rdy_out;
    // A full buffer still accepts a write when the head leaves in the same cycle.
    assign wr      = vld_in & (~full | pop);
    assign ovf     = vld_in & full & ~pop;
    assign iss_ok  = iss_in & rdy_iss;
    assign iss_bad = iss_in & ~rdy_iss;

    always_comb begin
        wr_ptr_next  = wr_ptr;
        rd_ptr_next  = rd_ptr;
        occ_next     = occ;
        crd_next     = crd_cnt;
        err_iss_next = err_iss;
        err_ovf_next = err_ovf;

        if (wr) begin
            wr_ptr_next = wr_ptr + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr + ADDR_W'(1);
        end

        occ_next = occ + CNT_W'(wr) - CNT_W'(pop);
        // A rejected issue is not charged, but a same-cycle pop still returns its credit.
        crd_next = crd_cnt - CNT_W'(iss_ok) + CNT_W'(pop);

        if (iss_bad) begin
            err_iss_next = 1'b1;
        end
        if (ovf) begin
            err_ovf_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            crd_cnt <= FULL;
            err_iss <= 1'b0;
            err_ovf <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_next;
            rd_ptr  <= rd_ptr_next;
            occ     <= occ_next;
            crd_cnt <= crd_next;
            err_iss <= err_iss_next;
            err_ovf <= err_ovf_next;
        end
    end

    // Storage carries no reset; stale entries are unreachable once occ is cleared.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= dat_in;
        end
    end

endmodule

// File: tb/tb_gen_pipe_crd_sink.sv
// Directed bench for gen_pipe_crd_sink with a data scoreboard and a credit/occupancy reference model.
module tb_gen_pipe_crd_sink;

    localparam int FIFO_D = 4;
    localparam int DAT_W  = 4;
    localparam int CNT_W  = $clog2(FIFO_D + 1);

    logic             clk;
    logic             rst_n;
    logic             iss_in;
    logic             rdy_iss;
    logic [DAT_W-1:0] dat_in;
    logic             vld_in;
    logic [DAT_W-1:0] dat_out;
    logic             vld_out;
    logic             rdy_out;
    logic [CNT_W-1:0] crd_cnt;
    logic [CNT_W-1:0] occ;
    logic             err_iss;
    logic             err_ovf;

    gen_pipe_crd_sink #(.FIFO_D(FIFO_D), .DAT_W(DAT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .iss_in  (iss_in),
        .rdy_iss (rdy_iss),
        .dat_in  (dat_in),
        .vld_in  (vld_in),
        .dat_out (dat_out),
        .vld_out (vld_out),
        .rdy_out (rdy_out),
        .crd_cnt (crd_cnt),
        .occ     (occ),
        .err_iss (err_iss),
        .err_ovf (err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_pop = 0;

    logic [DAT_W-1:0] sb_q [$];
    int m_occ;
    int m_crd;
    bit m_eiss;
    bit m_eovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_occ  = 0;
        m_crd  = FIFO_D;
        m_eiss = 1'b0;
        m_eovf = 1'b0;
        sb_q.delete();
    endtask

    task automatic do_reset(input int n);
        rst_n   = 1'b0;
        iss_in  = 1'b0;
        vld_in  = 1'b0;
        dat_in  = '0;
        rdy_out = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    // One clock: drive inputs, check pre-edge outputs and popped data, step model, check registers.
    task automatic cycle(input logic iss, input logic vld, input logic [DAT_W-1:0] d, input logic rdy);
        logic             m_pop;
        logic             m_wr;
        logic [DAT_W-1:0] exp_d;
        iss_in  = iss;
        vld_in  = vld;
        dat_in  = d;
        rdy_out = rdy;
        #1;
        chk("vld_out", vld_out, (m_occ != 0));
        m_pop = (m_occ != 0) && rdy;
        if (m_pop) begin
            exp_d = (sb_q.size() != 0) ? sb_q.pop_front() : 'x;
            chk("pop_dat", dat_out, exp_d);
            n_pop++;
        end
        m_wr = vld && ((m_occ < FIFO_D) || m_pop);
        if (m_wr) sb_q.push_back(d);
        if (vld && m_occ == FIFO_D && !m_pop) m_eovf = 1'b1;
        if (iss && m_crd == 0) m_eiss = 1'b1;
        m_crd = m_crd - int'(iss && m_crd != 0) + int'(m_pop);
        m_occ = m_occ + int'(m_wr) - int'(m_pop);
        @(posedge clk);
        #1;
        chk("occ", occ, m_occ);
        chk("crd_cnt", crd_cnt, m_crd);
        chk("rdy_iss", rdy_iss, (m_crd != 0));
        chk("err_iss", err_iss, m_eiss);
        chk("err_ovf", err_ovf, m_eovf);
    endtask

    initial begin
        int   n_iss;
        int   n_dlv;
        logic p_v0, p_v1;
        logic [DAT_W-1:0] p_d0, p_d1;
        logic iss;

        // Reset values
        do_reset(2);
        chk("rst_crd", crd_cnt, 4);
        chk("rst_occ", occ, 0);
        chk("rst_vld", vld_out, 0);
        chk("rst_dat", dat_out, 0);
        chk("rst_rdy_iss", rdy_iss, 1);
        chk("rst_err_iss", err_iss, 0);
        chk("rst_err_ovf", err_ovf, 0);

        // Single item through a 2-stage pipe
        cycle(1, 0, 4'h0, 1);
        chk("single_crd_c1", crd_cnt, 3);
        cycle(0, 0, 4'h0, 1);
        cycle(0, 1, 4'hA, 1);
        chk("single_vld_c3", vld_out, 1);
        chk("single_dat_c3", dat_out, 4'hA);
        cycle(0, 0, 4'h0, 1);
        chk("single_crd_c4", crd_cnt, 4);
        chk("single_vld_c4", vld_out, 0);

        // Fill and stall
        cycle(1, 0, 4'h0, 0);
        cycle(1, 0, 4'h0, 0);
        cycle(1, 1, 4'h1, 0);
        cycle(1, 1, 4'h2, 0);
        chk("fill_rdy_iss", rdy_iss, 0);
        cycle(0, 1, 4'h3, 0);
        cycle(0, 1, 4'h4, 0);
        chk("fill_occ", occ, 4);
        chk("fill_head", dat_out, 4'h1);
        cycle(1, 0, 4'h0, 0);
        chk("fill_err_iss", err_iss, 1);
        chk("fill_crd_zero", crd_cnt, 0);
        repeat (4) cycle(0, 0, 4'h0, 1);
        chk("drain_occ", occ, 0);
        chk("drain_crd", crd_cnt, 4);

        // Full write with simultaneous pop, then full write without pop
        do_reset(1);
        cycle(1, 0, 4'h0, 0);
        cycle(1, 0, 4'h0, 0);
        cycle(1, 1, 4'h1, 0);
        cycle(1, 1, 4'h2, 0);
        cycle(0, 1, 4'h3, 0);
        cycle(0, 1, 4'h4, 0);
        cycle(0, 1, 4'h5, 1);
        chk("fwp_err_ovf", err_ovf, 0);
        chk("fwp_occ", occ, 4);
        chk("fwp_head", dat_out, 4'h2);
        cycle(0, 1, 4'h6, 0);
        chk("ovf_err", err_ovf, 1);
        chk("ovf_occ", occ, 4);
        repeat (4) cycle(0, 0, 4'h0, 1);
        chk("ovf_drain_occ", occ, 0);

        // Wrap-around stream through a 2-stage pipe, consumer ready toggling
        do_reset(1);
        n_iss = 0;
        n_dlv = 0;
        n_pop = 0;
        p_v0 = 0; p_v1 = 0; p_d0 = '0; p_d1 = '0;
        for (int c = 0; c < 60 && n_pop < 10; c++) begin
            iss = (n_iss < 10) && (m_crd != 0);
            cycle(iss, p_v1, p_d1, (c % 2) == 0);
            if (p_v1) n_dlv++;
            p_v1 = p_v0;
            p_d1 = p_d0;
            p_v0 = iss;
            p_d0 = DAT_W'(n_iss);
            if (iss) n_iss++;
        end
        chk("wrap_pops", n_pop, 10);
        chk("wrap_dlv", n_dlv, 10);
        chk("wrap_err_iss", err_iss, 0);
        chk("wrap_err_ovf", err_ovf, 0);
        chk("wrap_crd", crd_cnt, 4);

        // Reset mid-operation
        cycle(1, 0, 4'h0, 0);
        cycle(1, 0, 4'h0, 0);
        cycle(1, 1, 4'h7, 0);
        cycle(0, 1, 4'h8, 0);
        cycle(0, 1, 4'h9, 0);
        chk("mid_occ", occ, 3);
        chk("mid_crd", crd_cnt, 1);
        do_reset(1);
        chk("mid_rst_occ", occ, 0);
        chk("mid_rst_crd", crd_cnt, 4);
        chk("mid_rst_vld", vld_out, 0);
        chk("mid_rst_dat", dat_out, 0);
        chk("mid_rst_err_iss", err_iss, 0);
        chk("mid_rst_err_ovf", err_ovf, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
